// File: rtl/ika9958_vram_sched_pkg.sv
// Shared types and widths for the IKA9958 VRAM slot scheduler.
package ika9958_pkg_sched;

  localparam int VRAM_AW = 17;
  localparam int VRAM_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_CMD  = 2'd3
  } owner_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/ika9958_vram_sched_arb.sv
// Slot-owner priority and next command-engine starvation count, evaluated
// for the slot that is starting this cycle.
module ika9958_sched_arb
  import ika9958_pkg_sched::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       slot_free,
  input  logic       cpu_req,
  input  logic       cmd_req,
  input  logic [2:0] starve_q,
  output logic [1:0] owner,
  output logic [2:0] starve_nxt
);

  logic cmd_forced;

  // The CPU keeps priority until the command engine has lost STARVE_MAX free slots in a row.
  assign cmd_forced = cmd_req && (starve_q == 3'(STARVE_MAX));

  always_comb begin
    owner      = OWN_NONE;
    starve_nxt = starve_q;
    if (!slot_free) begin
      owner = OWN_DISP;
    end else if (cpu_req && !cmd_forced) begin
      owner = OWN_CPU;
      if (cmd_req) begin
        starve_nxt = starve_q + 3'd1;
      end else begin
        starve_nxt = 3'd0;
      end
    end else if (cmd_req) begin
      owner      = OWN_CMD;
      starve_nxt = 3'd0;
    end else begin
      starve_nxt = 3'd0;
    end
  end

endmodule

// File: rtl/ika9958_vram_sched.sv
// IKA9958 VRAM slot scheduler: picks an owner at each slot start and runs a
// fixed-length access on the single VRAM port.
//
// state  | meaning
// IDLE   | waiting for an enabled slot start; o_OWNER reads 0
// ACCESS | slot in progress; counter runs 0..SLOT_LEN-1, then back to IDLE
module ika9958_vram_sched
  import ika9958_pkg_sched::*;
#(
  parameter int SLOT_LEN   = 8,
  parameter int RD_LAT     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        i_XTAL1,
  input  logic        i_RST_n,
  input  logic        i_XTAL_NCEN,
  input  logic        i_SLOT_START,
  input  logic        i_SLOT_FREE,
  input  logic [16:0] i_DISP_ADDR,
  output logic        o_DISP_ACK,
  output logic [7:0]  o_DISP_RDATA,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WE,
  input  logic [16:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_WDATA,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_CPU_RDATA,
  input  logic        i_CMD_REQ,
  input  logic        i_CMD_WE,
  input  logic [16:0] i_CMD_ADDR,
  input  logic [7:0]  i_CMD_WDATA,
  output logic        o_CMD_ACK,
  output logic [7:0]  o_CMD_RDATA,
  output logic        o_MEM_EN,
  output logic        o_MEM_WE,
  output logic [16:0] o_MEM_ADDR,
  output logic [7:0]  o_MEM_WDATA,
  input  logic [7:0]  i_MEM_RDATA,
  output logic [1:0]  o_OWNER,
  output logic        o_OVERRUN
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  owner_e             owner_q, owner_d;
  logic               we_q, we_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [VRAM_DW-1:0] wdata_q, wdata_d;
  logic               mem_en_q, mem_en_d;
  logic               disp_ack_q, disp_ack_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               cmd_ack_q, cmd_ack_d;
  logic [VRAM_DW-1:0] disp_rdata_q, disp_rdata_d;
  logic [VRAM_DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [VRAM_DW-1:0] cmd_rdata_q, cmd_rdata_d;
  logic               overrun_q, overrun_d;
  logic [2:0]         starve_q, starve_d;

  logic [1:0]         arb_owner;
  logic [2:0]         arb_starve;

  ika9958_sched_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .slot_free (i_SLOT_FREE),
    .cpu_req   (i_CPU_REQ),
    .cmd_req   (i_CMD_REQ),
    .starve_q  (starve_q),
    .owner     (arb_owner),
    .starve_nxt(arb_starve)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_en_d     = 1'b0;
    disp_ack_d   = 1'b0;
    cpu_ack_d    = 1'b0;
    cmd_ack_d    = 1'b0;
    disp_rdata_d = disp_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    cmd_rdata_d  = cmd_rdata_q;
    overrun_d    = 1'b0;
    starve_d     = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (i_SLOT_START) begin
          state_d  = ST_ACCESS;
          cnt_d    = 4'd0;
          owner_d  = owner_e'(arb_owner);
          starve_d = arb_starve;
          mem_en_d = (owner_e'(arb_owner) != OWN_NONE);
          case (owner_e'(arb_owner))
            OWN_DISP: begin
              we_d    = 1'b0;
              addr_d  = i_DISP_ADDR;
              wdata_d = '0;
            end
            OWN_CPU: begin
              we_d    = i_CPU_WE;
              addr_d  = i_CPU_ADDR;
              wdata_d = i_CPU_WDATA;
            end
            OWN_CMD: begin
              we_d    = i_CMD_WE;
              addr_d  = i_CMD_ADDR;
              wdata_d = i_CMD_WDATA;
            end
            default: begin
              we_d    = 1'b0;
              addr_d  = '0;
              wdata_d = '0;
            end
          endcase
        end
      end

      ST_ACCESS: begin
        overrun_d = i_SLOT_START;
        // Data is sampled on the edge closing count RD_LAT-1; ack shows in the following cycle.
        if (cnt_q == 4'(RD_LAT - 1)) begin
          case (owner_q)
            OWN_DISP: begin
              disp_ack_d   = 1'b1;
              disp_rdata_d = i_MEM_RDATA;
            end
            OWN_CPU: begin
              cpu_ack_d = 1'b1;
              if (!we_q) cpu_rdata_d = i_MEM_RDATA;
            end
            OWN_CMD: begin
              cmd_ack_d = 1'b1;
              if (!we_q) cmd_rdata_d = i_MEM_RDATA;
            end
            default: ;
          endcase
        end
        if (cnt_q == 4'(SLOT_LEN - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          owner_d = OWN_NONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge i_XTAL1) begin
    if (!i_RST_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= OWN_NONE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_en_q     <= 1'b0;
      disp_ack_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cmd_ack_q    <= 1'b0;
      disp_rdata_q <= '0;
      cpu_rdata_q  <= '0;
      cmd_rdata_q  <= '0;
      overrun_q    <= 1'b0;
      starve_q     <= 3'd0;
    end else if (!i_XTAL_NCEN) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_en_q     <= mem_en_d;
      disp_ack_q   <= disp_ack_d;
      cpu_ack_q    <= cpu_ack_d;
      cmd_ack_q    <= cmd_ack_d;
      disp_rdata_q <= disp_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cmd_rdata_q  <= cmd_rdata_d;
      overrun_q    <= overrun_d;
      starve_q     <= starve_d;
    end
  end

  assign o_OWNER      = owner_q;
  assign o_MEM_EN     = mem_en_q;
  assign o_MEM_WE     = we_q;
  assign o_MEM_ADDR   = addr_q;
  assign o_MEM_WDATA  = wdata_q;
  assign o_DISP_ACK   = disp_ack_q;
  assign o_DISP_RDATA = disp_rdata_q;
  assign o_CPU_ACK    = cpu_ack_q;
  assign o_CPU_RDATA  = cpu_rdata_q;
  assign o_CMD_ACK    = cmd_ack_q;
  assign o_CMD_RDATA  = cmd_rdata_q;
  assign o_OVERRUN    = overrun_q;

endmodule

// File: tb/tb_ika9958_vram_sched.sv
// Bench for the VRAM slot scheduler: a slot-level reference model predicts
// owner, strobe, ack timing and read data for directed and random slots.
module tb_ika9958_vram_sched;

  localparam int SLOT_LEN   = 8;
  localparam int RD_LAT     = 4;
  localparam int STARVE_MAX = 3;
  localparam int O_NONE = 0, O_DISP = 1, O_CPU = 2, O_CMD = 3;

  logic        clk = 1'b0;
  logic        i_RST_n, i_XTAL_NCEN, i_SLOT_START, i_SLOT_FREE;
  logic [16:0] i_DISP_ADDR, i_CPU_ADDR, i_CMD_ADDR;
  logic        i_CPU_REQ, i_CPU_WE, i_CMD_REQ, i_CMD_WE;
  logic [7:0]  i_CPU_WDATA, i_CMD_WDATA, i_MEM_RDATA;
  logic        o_DISP_ACK, o_CPU_ACK, o_CMD_ACK, o_MEM_EN, o_MEM_WE, o_OVERRUN;
  logic [7:0]  o_DISP_RDATA, o_CPU_RDATA, o_CMD_RDATA, o_MEM_WDATA;
  logic [16:0] o_MEM_ADDR;
  logic [1:0]  o_OWNER;

  always #5 clk = ~clk;

  ika9958_vram_sched #(
    .SLOT_LEN(SLOT_LEN), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_XTAL1(clk), .i_RST_n(i_RST_n), .i_XTAL_NCEN(i_XTAL_NCEN),
    .i_SLOT_START(i_SLOT_START), .i_SLOT_FREE(i_SLOT_FREE),
    .i_DISP_ADDR(i_DISP_ADDR), .o_DISP_ACK(o_DISP_ACK), .o_DISP_RDATA(o_DISP_RDATA),
    .i_CPU_REQ(i_CPU_REQ), .i_CPU_WE(i_CPU_WE), .i_CPU_ADDR(i_CPU_ADDR),
    .i_CPU_WDATA(i_CPU_WDATA), .o_CPU_ACK(o_CPU_ACK), .o_CPU_RDATA(o_CPU_RDATA),
    .i_CMD_REQ(i_CMD_REQ), .i_CMD_WE(i_CMD_WE), .i_CMD_ADDR(i_CMD_ADDR),
    .i_CMD_WDATA(i_CMD_WDATA), .o_CMD_ACK(o_CMD_ACK), .o_CMD_RDATA(o_CMD_RDATA),
    .o_MEM_EN(o_MEM_EN), .o_MEM_WE(o_MEM_WE), .o_MEM_ADDR(o_MEM_ADDR),
    .o_MEM_WDATA(o_MEM_WDATA), .i_MEM_RDATA(i_MEM_RDATA),
    .o_OWNER(o_OWNER), .o_OVERRUN(o_OVERRUN)
  );

  // VRAM behind the port: unwritten locations return a fixed address pattern.
  logic [7:0]  env_mem [0:131071];
  bit          env_wr  [0:131071];
  logic        poke_en = 1'b0;
  logic [16:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  function automatic logic [7:0] pat(input logic [16:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8];
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      env_mem[poke_addr] <= poke_data;
      env_wr[poke_addr]  <= 1'b1;
    end else if (i_RST_n && !i_XTAL_NCEN && o_MEM_EN && o_MEM_WE) begin
      env_mem[o_MEM_ADDR] <= o_MEM_WDATA;
      env_wr[o_MEM_ADDR]  <= 1'b1;
    end
  end

  assign i_MEM_RDATA = env_wr[o_MEM_ADDR] ? env_mem[o_MEM_ADDR] : pat(o_MEM_ADDR);

  // Reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_starve = 0;
  logic [7:0]  m_rd [0:3];
  logic [7:0]  ref_mem [0:131071];
  bit          ref_wr  [0:131071];
  int          last_own_obs;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_owner"},  32'(o_OWNER), 0);
    chk({tag, "_mem_en"}, 32'(o_MEM_EN), 0);
    chk({tag, "_mem_we"}, 32'(o_MEM_WE), 0);
    chk({tag, "_addr"},   32'(o_MEM_ADDR), 0);
    chk({tag, "_wdata"},  32'(o_MEM_WDATA), 0);
    chk({tag, "_acks"},   32'({o_DISP_ACK, o_CPU_ACK, o_CMD_ACK}), 0);
    chk({tag, "_rdata"},  32'({o_DISP_RDATA, o_CPU_RDATA, o_CMD_RDATA}), 0);
    chk({tag, "_ovr"},    32'(o_OVERRUN), 0);
  endtask

  task automatic scramble();
    i_SLOT_FREE = 1'($urandom_range(0, 1));
    i_DISP_ADDR = 17'($urandom);
    i_CPU_REQ   = 1'($urandom_range(0, 1));
    i_CPU_WE    = 1'($urandom_range(0, 1));
    i_CPU_ADDR  = 17'($urandom);
    i_CPU_WDATA = 8'($urandom);
    i_CMD_REQ   = 1'($urandom_range(0, 1));
    i_CMD_WE    = 1'($urandom_range(0, 1));
    i_CMD_ADDR  = 17'($urandom);
    i_CMD_WDATA = 8'($urandom);
  endtask

  function automatic logic [7:0] ref_rd(input logic [16:0] a);
    return ref_wr[a] ? ref_mem[a] : pat(a);
  endfunction

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    i_SLOT_START = 1'b0;
    tick();
    poke_en = 1'b0;
    ref_mem[a] = d; ref_wr[a] = 1'b1;
  endtask

  // Issue one slot from IDLE and follow it cycle by cycle until it is back in IDLE.
  task automatic run_slot(input bit free, input bit creq, input bit cwe, input logic [16:0] caddr,
                          input logic [7:0] cwd, input bit mreq, input bit mwe,
                          input logic [16:0] maddr, input logic [7:0] mwd,
                          input logic [16:0] daddr, input int ovr_at, input bit stall);
    int          own, k, ovr_k;
    logic        e_we;
    logic [16:0] e_addr;
    logic [7:0]  e_wd, e_rd;
    bit          done;
    if (!free) own = O_DISP;
    else if (creq && !(mreq && m_starve == STARVE_MAX)) own = O_CPU;
    else if (mreq) own = O_CMD;
    else own = O_NONE;
    if (free) begin
      if (own == O_CPU && mreq) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
      else m_starve = 0;
    end
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (own == O_DISP) e_addr = daddr;
    if (own == O_CPU) begin e_we = cwe; e_addr = caddr; e_wd = cwd; end
    if (own == O_CMD) begin e_we = mwe; e_addr = maddr; e_wd = mwd; end
    e_rd = ref_rd(e_addr);
    if (own != O_NONE && e_we) begin ref_mem[e_addr] = e_wd; ref_wr[e_addr] = 1'b1; end

    i_SLOT_START = 1'b1; i_XTAL_NCEN = 1'b0; i_SLOT_FREE = free; i_DISP_ADDR = daddr;
    i_CPU_REQ = creq; i_CPU_WE = cwe; i_CPU_ADDR = caddr; i_CPU_WDATA = cwd;
    i_CMD_REQ = mreq; i_CMD_WE = mwe; i_CMD_ADDR = maddr; i_CMD_WDATA = mwd;
    k = 0; ovr_k = -1; done = 1'b0;
    tick();
    for (int it = 0; it < 100; it++) begin
      if (k == RD_LAT && own != O_NONE && !e_we) m_rd[own] = e_rd;
      if (k == 0) last_own_obs = int'(o_OWNER);
      chk("owner", 32'(o_OWNER), (k < SLOT_LEN) ? own : 0);
      chk("mem_en", 32'(o_MEM_EN), 32'(k == 0 && own != O_NONE));
      chk("disp_ack", 32'(o_DISP_ACK), 32'(k == RD_LAT && own == O_DISP));
      chk("cpu_ack", 32'(o_CPU_ACK), 32'(k == RD_LAT && own == O_CPU));
      chk("cmd_ack", 32'(o_CMD_ACK), 32'(k == RD_LAT && own == O_CMD));
      chk("overrun", 32'(o_OVERRUN), 32'(k == ovr_k));
      if (k < SLOT_LEN && own != O_NONE) begin
        chk("mem_addr", 32'(o_MEM_ADDR), 32'(e_addr));
        chk("mem_we", 32'(o_MEM_WE), 32'(e_we));
        if (e_we) chk("mem_wdata", 32'(o_MEM_WDATA), 32'(e_wd));
      end
      chk("disp_rdata", 32'(o_DISP_RDATA), 32'(m_rd[O_DISP]));
      chk("cpu_rdata", 32'(o_CPU_RDATA), 32'(m_rd[O_CPU]));
      chk("cmd_rdata", 32'(o_CMD_RDATA), 32'(m_rd[O_CMD]));
      if (k == SLOT_LEN) begin
        done = 1'b1;
        break;
      end
      scramble();
      if (k == ovr_at && ovr_k < 0) begin
        i_SLOT_START = 1'b1; i_XTAL_NCEN = 1'b0; ovr_k = k + 1;
      end else begin
        i_SLOT_START = 1'b0;
        i_XTAL_NCEN = stall ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (!i_XTAL_NCEN) k++;
      tick();
    end
    chk("slot_done", 32'(done), 1);
  endtask

  task automatic idle_cycle();
    scramble();
    i_SLOT_START = 1'($urandom_range(0, 1));
    i_XTAL_NCEN  = i_SLOT_START ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    chk("idle_owner", 32'(o_OWNER), 0);
    chk("idle_mem_en", 32'(o_MEM_EN), 0);
    chk("idle_acks", 32'({o_DISP_ACK, o_CPU_ACK, o_CMD_ACK}), 0);
  endtask

  initial begin
    int obs_seq [5];
    int exp_seq [5] = '{O_CPU, O_CPU, O_CPU, O_CMD, O_CPU};
    logic [16:0] base;
    int ov;

    for (int i = 0; i < 4; i++) m_rd[i] = 8'h00;
    i_RST_n = 1'b0; i_XTAL_NCEN = 1'b0; i_SLOT_START = 1'b0; i_SLOT_FREE = 1'b0;
    i_DISP_ADDR = '0; i_CPU_REQ = 1'b0; i_CPU_WE = 1'b0; i_CPU_ADDR = '0; i_CPU_WDATA = '0;
    i_CMD_REQ = 1'b0; i_CMD_WE = 1'b0; i_CMD_ADDR = '0; i_CMD_WDATA = '0;
    tick(); tick();
    chk_zero("reset");
    i_RST_n = 1'b1;
    tick();

    // Reserved slot while the CPU also requests
    poke(17'h1_2345, 8'hA5);
    run_slot(1'b0, 1'b1, 1'b0, 17'h0_0020, 8'h00, 1'b0, 1'b0, 17'h0, 8'h00, 17'h1_2345, -1, 1'b0);
    chk("disp_rdata_a5", 32'(o_DISP_RDATA), 32'h0000_00A5);

    // CPU write on a free slot, command engine idle
    run_slot(1'b1, 1'b1, 1'b1, 17'h0_0010, 8'h5A, 1'b0, 1'b0, 17'h0, 8'h00, 17'h0, -1, 1'b0);
    chk("cpu_rdata_kept", 32'(o_CPU_RDATA), 0);

    // CPU and command engine both requesting across five free slots
    for (int i = 0; i < 5; i++) begin
      run_slot(1'b1, 1'b1, 1'b0, 17'h0_0010, 8'h00, 1'b1, 1'b0, 17'h0_0011, 8'h00, 17'h0, -1, 1'b0);
      obs_seq[i] = last_own_obs;
    end
    for (int i = 0; i < 5; i++) chk("starve_seq", 32'(obs_seq[i]), 32'(exp_seq[i]));

    // Slot start mid-slot and on the final cycle, then one immediately after
    run_slot(1'b1, 1'b1, 1'b0, 17'h0_0010, 8'h00, 1'b0, 1'b0, 17'h0, 8'h00, 17'h0, 3, 1'b0);
    run_slot(1'b1, 1'b0, 1'b0, 17'h0, 8'h00, 1'b1, 1'b1, 17'h0_0030, 8'hC3, 17'h0, SLOT_LEN - 1, 1'b0);
    run_slot(1'b1, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 17'h0, 8'h00, 17'h0, -1, 1'b0);
    run_slot(1'b0, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 17'h0, 8'h00, 17'h0_0030, -1, 1'b0);
    chk("disp_reads_cmd_write", 32'(o_DISP_RDATA), 32'h0000_00C3);

    // Slot start while the clock enable is off is ignored
    i_SLOT_START = 1'b1; i_SLOT_FREE = 1'b1; i_CPU_REQ = 1'b1; i_XTAL_NCEN = 1'b1;
    tick();
    i_SLOT_START = 1'b0; i_XTAL_NCEN = 1'b0;
    tick();
    chk("ncen_start_owner", 32'(o_OWNER), 0);
    chk("ncen_start_mem_en", 32'(o_MEM_EN), 0);

    // Reset in the middle of a CPU read with the clock enable off
    i_SLOT_START = 1'b1; i_SLOT_FREE = 1'b1; i_CPU_REQ = 1'b1; i_CPU_WE = 1'b0;
    i_CPU_ADDR = 17'h0_0044; i_CMD_REQ = 1'b0;
    tick();
    i_SLOT_START = 1'b0;
    tick(); tick();
    i_RST_n = 1'b0; i_XTAL_NCEN = 1'b1;
    tick();
    chk_zero("rst_mid");
    m_starve = 0;
    for (int i = 0; i < 4; i++) m_rd[i] = 8'h00;
    tick();
    i_RST_n = 1'b1; i_XTAL_NCEN = 1'b0; i_CPU_REQ = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rst_no_ack", 32'({o_DISP_ACK, o_CPU_ACK, o_CMD_ACK}), 0);
      chk("rst_owner", 32'(o_OWNER), 0);
    end

    // Random slots with clock-enable stalls and occasional overruns
    base = 17'h0_0400;
    for (int s = 0; s < 150; s++) begin
      ov = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, SLOT_LEN - 1)) : -1;
      run_slot(1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               base + 17'($urandom_range(0, 15)), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               base + 17'($urandom_range(0, 15)), 8'($urandom),
               base + 17'($urandom_range(0, 15)), ov, 1'b1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ika9958_vram_sched.md
Name: ika9958_vram_sched

Overview:
- VRAM access-slot scheduler for the IKA9958 core. Sits between screen timing, which marks slot boundaries and whether each slot is display-reserved, and the single VRAM port.
- Shares the port between display fetch, CPU port accesses and the command engine.
- Sequences each access as a fixed-length slot: latches owner/address, strobes memory, captures read data, acknowledges the winner.

Parameters:
- SLOT_LEN, 8, enabled cycles per access slot (legal 4..15).
- RD_LAT, 4, enabled cycles from slot start to read-data capture/ack (legal 1..SLOT_LEN-1).
- STARVE_MAX, 3, consecutive CPU wins on free slots while command engine waits before command engine is forced (legal 1..7).

Ports:
- i_XTAL1  in  1  master clock
- i_RST_n  in  1  reset
- i_XTAL_NCEN  in  1  active-low clock enable; all non-reset state advances only when low
- i_SLOT_START  in  1  one-enabled-cycle pulse: a VRAM slot begins
- i_SLOT_FREE  in  1  sampled with i_SLOT_START; 1 = slot available to CPU/command, 0 = display-reserved
- i_DISP_ADDR  in  17  display fetch address for reserved slots
- o_DISP_ACK  out  1  display read data valid
- o_DISP_RDATA  out  8  display read data
- i_CPU_REQ  in  1  CPU request level
- i_CPU_WE  in  1  CPU write enable
- i_CPU_ADDR  in  17  CPU address
- i_CPU_WDATA  in  8  CPU write data
- o_CPU_ACK  out  1  one-cycle CPU completion pulse
- o_CPU_RDATA  out  8  CPU read data
- i_CMD_REQ  in  1  command-engine request level
- i_CMD_WE  in  1  command-engine write enable
- i_CMD_ADDR  in  17  command-engine address
- i_CMD_WDATA  in  8  command-engine write data
- o_CMD_ACK  out  1  one-cycle command-engine completion pulse
- o_CMD_RDATA  out  8  command-engine read data
- o_MEM_EN  out  1  memory strobe, one enabled cycle
- o_MEM_WE  out  1  memory write enable
- o_MEM_ADDR  out  17  memory address
- o_MEM_WDATA  out  8  memory write data
- i_MEM_RDATA  in  8  memory read data
- o_OWNER  out  2  current slot owner: 0 NONE, 1 DISP, 2 CPU, 3 CMD
- o_OVERRUN  out  1  one-cycle pulse: slot start arrived while busy

Behaviour:
- Clock and reset: one clock, i_XTAL1. Reset is i_RST_n, synchronous and active-low.
- Reset overrides i_XTAL_NCEN. All outputs 0, FSM IDLE, counters 0, owner NONE. Reset mid-slot abandons the access with no ack.
- FSM: IDLE -> ACCESS on i_SLOT_START; ACCESS -> IDLE when slot counter reaches SLOT_LEN-1. Counter is 4 bits, counts enabled cycles from 0 at the cycle after start.
- Arbitration, evaluated combinationally at i_SLOT_START:
  - reserved slot -> DISP;
  - free slot: CPU if i_CPU_REQ, unless starvation count == STARVE_MAX and i_CMD_REQ, then CMD;
  - else CMD if i_CMD_REQ; else NONE.
- Owner, WE, address and wdata are latched at the start edge. Requester inputs are don't-care afterwards.
- Starvation counter (3 bits):
  - +1 when CPU wins a free slot while i_CMD_REQ = 1;
  - cleared when CMD wins or i_CMD_REQ = 0 at a free slot start;
  - saturates at STARVE_MAX.
- o_MEM_EN: high for exactly the first enabled cycle of ACCESS when owner != NONE. o_MEM_ADDR/WE/WDATA hold latched values for the whole slot. DISP is always a read.
- At counter == RD_LAT-1:
  - i_MEM_RDATA is captured into the owner's RDATA register (not for writes);
  - the owner's ACK pulses for one enabled cycle;
  - latency is RD_LAT enabled cycles after the start cycle.
- RDATA registers hold until the next capture for that owner.
- NONE slot: no strobe, no ack; FSM still occupies SLOT_LEN cycles.
- Requester protocol:
  - hold REQ until ACK;
  - REQ still high the cycle after ACK counts as a new request;
  - REQ dropped mid-slot: access completes and ACK still pulses.
- i_SLOT_START while in ACCESS (including the final cycle): ignored, o_OVERRUN pulses, current slot unaffected.
- i_SLOT_START with i_XTAL_NCEN high: ignored.
- o_OWNER shows the latched owner during ACCESS and 0 in IDLE.

Decomposition:
- Package ika9958_pkg_sched holds:
  - owner enum (NONE/DISP/CPU/CMD, 2 bits);
  - FSM state enum;
  - VRAM_AW = 17 and VRAM_DW = 8.
- One natural sub-module: ika9958_sched_arb, the combinational priority plus starvation-counter logic. Slot sequencing stays in the top.

Test Plan:
- Reset: assert i_RST_n = 0 mid-slot with i_XTAL_NCEN held high -> next edge all outputs 0, o_OWNER = 0, no ack ever issued for the aborted slot.
- Reserved slot, i_DISP_ADDR = 17'h1_2345, i_MEM_RDATA = 8'hA5, CPU also requesting -> o_MEM_ADDR = 17'h1_2345, o_MEM_EN pulse 1 cycle, o_DISP_ACK at enabled cycle 4, o_DISP_RDATA = A5, no o_CPU_ACK.
- Free slot, CPU write addr 17'h0_0010, data 8'h5A, CMD idle -> o_MEM_WE = 1, o_MEM_WDATA = 5A, o_CPU_ACK after 4 enabled cycles, o_CPU_RDATA unchanged.
- CPU and CMD both held requesting across 5 free slots, STARVE_MAX = 3 -> owners CPU, CPU, CPU, CMD, CPU.
- i_SLOT_START pulsed 3 cycles into a slot -> o_OVERRUN pulse, slot length unchanged at 8, single ack.
- Free slot with no requests -> o_OWNER = 0, no o_MEM_EN, no acks, next slot start accepted after 8 cycles.
